// File: rtl/pulse_train_gen.sv
// Pulse train generator: turns an accepted count into single-cycle pulses
// separated by a programmable number of idle cycles, with busy/remaining/done status.
module pulse_train_gen #(
   parameter int WIDTH = 32,
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_cmd_valid,
   output logic             io_cmd_ready,
   input  logic [WIDTH-1:0] io_cmd_count,
   input  logic [GAP_W-1:0] io_cmd_gap,
   input  logic             io_abort,
   output logic             io_pulse,
   output logic             io_busy,
   output logic [WIDTH-1:0] io_remaining,
   output logic             io_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] remaining;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_reload;
   logic             done;

   assign io_pulse     = (state == PULSE);
   assign io_busy      = (state != IDLE);
   assign io_cmd_ready = (state == IDLE);
   assign io_remaining = remaining;
   assign io_done      = done;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch below sees the pre-edge values of state/remaining/gap_cnt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         remaining  <= '0;
         gap_cnt    <= '0;
         gap_reload <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // io_abort is ignored here so it cannot block an accept.
               if (io_cmd_valid) begin
                  if (io_cmd_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     remaining  <= io_cmd_count;
                     gap_reload <= io_cmd_gap;
                     state      <= PULSE;
                  end
               end
            end
            PULSE: begin
               if (io_abort) begin
                  state     <= IDLE;
                  remaining <= '0;
                  gap_cnt   <= '0;
               end else begin
                  remaining <= remaining - WIDTH'(1);
                  if (remaining == WIDTH'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else if (gap_reload == '0) begin
                     state <= PULSE;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= gap_reload;
                  end
               end
            end
            GAP: begin
               if (io_abort) begin
                  state     <= IDLE;
                  remaining <= '0;
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
                  if (gap_cnt == GAP_W'(1)) state <= PULSE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: inputs change and outputs are checked
// on the falling edge; a pulse counter on the rising edge acts as the consumer.
module tb_pulse_train_gen;

   localparam int WIDTH = 32;
   localparam int GAP_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             io_cmd_valid;
   logic             io_cmd_ready;
   logic [WIDTH-1:0] io_cmd_count;
   logic [GAP_W-1:0] io_cmd_gap;
   logic             io_abort;
   logic             io_pulse;
   logic             io_busy;
   logic [WIDTH-1:0] io_remaining;
   logic             io_done;

   int n_vec = 0;
   int n_err = 0;
   int pulse_total = 0;
   int done_total = 0;
   int base_p;
   int base_d;

   pulse_train_gen #(.WIDTH(WIDTH), .GAP_W(GAP_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_cmd_valid (io_cmd_valid),
      .io_cmd_ready (io_cmd_ready),
      .io_cmd_count (io_cmd_count),
      .io_cmd_gap   (io_cmd_gap),
      .io_abort     (io_abort),
      .io_pulse     (io_pulse),
      .io_busy      (io_busy),
      .io_remaining (io_remaining),
      .io_done      (io_done)
   );

   always #5 clk = ~clk;

   // Conditional-increment consumer counters.
   always @(posedge clk) begin
      if (io_pulse) pulse_total <= pulse_total + 1;
      if (io_done)  done_total  <= done_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] cnt, input logic [7:0] gap);
      io_cmd_valid = 1'b1;
      io_cmd_count = cnt;
      io_cmd_gap   = gap;
      tick();
      io_cmd_valid = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      io_cmd_valid = 1'b0;
      io_cmd_count = '0;
      io_cmd_gap   = '0;
      io_abort     = 1'b0;
      tick(); tick();
      reset = 1'b1;

      chk("rst_busy", io_busy, 0);
      chk("rst_pulse", io_pulse, 0);
      chk("rst_ready", io_cmd_ready, 1);
      chk("rst_rem", io_remaining, 0);
      chk("rst_done", io_done, 0);

      // Back-to-back pulses: count=4, gap=0.
      send(4, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b_pulse%0d", k), io_pulse, 1);
         chk($sformatf("b2b_rem%0d", k), io_remaining, 32'(4 - k));
         chk($sformatf("b2b_done%0d", k), io_done, 0);
         tick();
      end
      chk("b2b_done", io_done, 1);
      chk("b2b_pulse_end", io_pulse, 0);
      chk("b2b_busy_end", io_busy, 0);
      tick();
      chk("b2b_done_clr", io_done, 0);

      // Gapped pulses: count=3, gap=2 -> pulses at t+1, t+4, t+7.
      send(3, 2);
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("gap_pulse_c%0d", c), io_pulse, (c == 1 || c == 4 || c == 7) ? 1 : 0);
         chk($sformatf("gap_busy_c%0d", c), io_busy, 1);
         chk($sformatf("gap_rem_c%0d", c), io_remaining, (c <= 1) ? 3 : (c <= 4) ? 2 : 1);
         tick();
      end
      chk("gap_done", io_done, 1);
      chk("gap_busy_end", io_busy, 0);
      tick();
      chk("gap_done_clr", io_done, 0);

      // Zero count: immediate done, never busy.
      base_p = pulse_total;
      send(0, 5);
      chk("zero_done", io_done, 1);
      chk("zero_busy", io_busy, 0);
      chk("zero_ready", io_cmd_ready, 1);
      chk("zero_rem", io_remaining, 0);
      tick();
      chk("zero_done_clr", io_done, 0);
      chk("zero_no_pulse", pulse_total - base_p, 0);

      // Abort in the cycle of the 3rd pulse: count=10, gap=1.
      base_p = pulse_total;
      base_d = done_total;
      send(10, 1);
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("abt_pulse_c%0d", c), io_pulse, (c % 2 == 1) ? 1 : 0);
         if (c == 5) io_abort = 1'b1;
         tick();
      end
      io_abort = 1'b0;
      chk("abt_busy", io_busy, 0);
      chk("abt_ready", io_cmd_ready, 1);
      chk("abt_rem", io_remaining, 0);
      chk("abt_pulse_after", io_pulse, 0);
      for (int c = 0; c < 6; c++) tick();
      chk("abt_pulse_count", pulse_total - base_p, 3);
      chk("abt_no_done", done_total - base_d, 0);

      // Abort while idle must not block a same-cycle accept.
      io_abort = 1'b1;
      send(1, 0);
      io_abort = 1'b0;
      chk("idle_abt_pulse", io_pulse, 1);
      chk("idle_abt_rem", io_remaining, 1);
      tick();
      chk("idle_abt_done", io_done, 1);
      tick();

      // Reset mid-train: count=5, gap=2.
      base_d = done_total;
      send(5, 2);
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      chk("mrst_busy", io_busy, 0);
      chk("mrst_pulse", io_pulse, 0);
      chk("mrst_rem", io_remaining, 0);
      chk("mrst_ready", io_cmd_ready, 1);
      reset = 1'b1;
      tick(); tick();
      chk("mrst_busy_after", io_busy, 0);
      chk("mrst_no_done", done_total - base_d, 0);

      // Chaining: second command held valid through the first train's done cycle.
      base_p = pulse_total;
      send(2, 1);
      io_cmd_valid = 1'b1;
      io_cmd_count = 2;
      io_cmd_gap   = 0;
      chk("ch_t1_pulse", io_pulse, 1);
      chk("ch_t1_ready", io_cmd_ready, 0);
      tick();
      chk("ch_t2_gap_kept", io_pulse, 0);
      tick();
      chk("ch_t3_pulse", io_pulse, 1);
      tick();
      chk("ch_t4_done", io_done, 1);
      chk("ch_t4_ready", io_cmd_ready, 1);
      tick();
      io_cmd_valid = 1'b0;
      chk("ch_t5_pulse", io_pulse, 1);
      chk("ch_t5_rem", io_remaining, 2);
      tick();
      chk("ch_t6_pulse", io_pulse, 1);
      chk("ch_t6_rem", io_remaining, 1);
      tick();
      chk("ch_t7_done", io_done, 1);
      tick();
      chk("ch_total", pulse_total - base_p, 4);

      // Maximum gap: count=2, gap=255 -> pulses at t+1 and t+257, done at t+258.
      base_p = pulse_total;
      send(2, 8'hFF);
      chk("mg_first", io_pulse, 1);
      for (int c = 2; c <= 256; c++) tick();
      chk("mg_quiet", pulse_total - base_p, 1);
      chk("mg_busy", io_busy, 1);
      tick();
      chk("mg_second", io_pulse, 1);
      tick();
      chk("mg_done", io_done, 1);

      // Maximum count: remaining starts at all-ones, then abort.
      send(32'hFFFF_FFFF, 0);
      chk("mc_rem0", io_remaining, 32'hFFFF_FFFF);
      tick();
      chk("mc_rem1", io_remaining, 32'hFFFF_FFFE);
      chk("mc_pulse", io_pulse, 1);
      io_abort = 1'b1;
      tick();
      io_abort = 1'b0;
      chk("mc_abt_rem", io_remaining, 0);
      chk("mc_abt_busy", io_busy, 0);
      tick();
      chk("mc_no_done", io_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Converts a loaded count into a train of single-cycle pulses on io_pulse, with a programmable idle gap between pulses.
- It is the producing end of the conditional-increment counter interface: an accumulating counter that adds 1 per io_in pulse, fed by this block, ends up holding the loaded count.
- Sits between a command source (valid/ready) and any pulse-counting consumer.
- Reports busy, remaining pulses, and a one-cycle completion strobe.

Parameters:
- WIDTH, 32, width of the pulse count and of io_remaining.
- GAP_W, 8, width of the inter-pulse gap field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- io_cmd_valid  input  1  command present.
- io_cmd_ready  output  1  block can accept a command.
- io_cmd_count  input  WIDTH  number of pulses to emit.
- io_cmd_gap  input  GAP_W  idle cycles between consecutive pulses.
- io_abort  input  1  terminate the current train.
- io_pulse  output  1  one-cycle pulse, one per counted event.
- io_busy  output  1  a train is in progress.
- io_remaining  output  WIDTH  pulses not yet completed.
- io_done  output  1  one-cycle strobe after the last pulse of a train.

Behaviour:
- States: IDLE, PULSE, GAP. State register, remaining counter (WIDTH), gap counter and gap reload (GAP_W), done register.
- Reset (reset==0 at an edge) forces the following, regardless of state or in-flight train:
  - state=IDLE, remaining=0, gap counter=0, done=0.
  - Outputs after reset: io_pulse=0, io_busy=0, io_cmd_ready=1, io_remaining=0, io_done=0.
- Combinational outputs:
  - io_pulse = (state==PULSE).
  - io_busy = (state!=IDLE).
  - io_cmd_ready = (state==IDLE).
  - io_remaining = remaining register.
- IDLE, accept = io_cmd_valid & io_cmd_ready:
  - count==0: no pulses; io_done=1 next cycle; stay IDLE; remaining stays 0.
  - count!=0: remaining<=count, gap reload<=gap, state<=PULSE.
  - Command inputs are sampled only on the accept edge; later changes are ignored.
- PULSE: io_pulse=1 for exactly this cycle; remaining<=remaining-1 at the edge. Next state:
  - remaining==1: state<=IDLE, done<=1.
  - else if gap reload==0: stay PULSE (back-to-back pulses).
  - else: state<=GAP, gap counter<=gap reload.
- GAP: io_pulse=0; gap counter decrements each edge. When gap counter==1, state<=PULSE. Exactly gap idle cycles separate consecutive pulses.
- Timing:
  - Accept at edge t: first pulse occupies the cycle after t.
  - Pulse k (k=0..N-1) occupies cycle t+1+k*(gap+1).
  - io_done is high in cycle t+1+(N-1)*(gap+1)+1, with state already IDLE.
- io_done:
  - Registered; high for exactly one cycle, then cleared.
  - A new command may be accepted in the io_done cycle, giving zero dead cycles between trains.
- io_abort in PULSE or GAP:
  - State<=IDLE, remaining<=0, gap counter<=0, no io_done.
  - An io_pulse already high in the abort cycle still appears on the port but is not followed by any further pulse.
  - io_abort in IDLE has no effect and does not block an accept in the same cycle.
- Reset mid-train: train is discarded, no io_done, and reset values as above.
- Arithmetic:
  - remaining never wraps: decrement happens only in PULSE with remaining>=1.
  - Maximum count 2^WIDTH-1 is legal and emits that many pulses.
  - gap up to 2^GAP_W-1 is legal.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-train (count=5, gap=2) -> io_busy=0, io_pulse=0, io_remaining=0, io_cmd_ready=1, no io_done.
- Back-to-back: cmd count=4, gap=0 accepted at edge t -> io_pulse high in cycles t+1..t+4, io_remaining 4,3,2,1 during those cycles, io_done=1 in t+5 only.
- Gap: cmd count=3, gap=2 at edge t -> pulses at t+1, t+4, t+7; io_done at t+8; io_busy high t+1..t+7.
- Zero count: cmd count=0, gap=5 -> no io_pulse, io_done=1 the next cycle, io_busy stays 0.
- Abort: count=10, gap=1; io_abort in the cycle of the 3rd pulse -> exactly 3 pulses total, IDLE next cycle, io_remaining=0, no io_done.
- Chaining/scoreboard: second cmd (count=2, gap=0) held valid through the io_done cycle of a first train (count=2, gap=1) -> accepted on the io_done cycle. A conditional-increment counter driven by io_pulse must read exactly 4 after both trains, with no lost or extra pulses.
